// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage types: physical register ids, free-list pointers and
// the sizing constants used by the free list and its checkpoint table.
package phys_free_list_pkg;

    localparam int PREG_W    = 7;
    localparam int NUM_PREGS = 128;
    localparam int NUM_AREGS = 32;
    localparam int NUM_CKPT  = 4;
    localparam int CKPT_W    = 2;
    localparam int PTR_W     = PREG_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;
    typedef logic [CKPT_W-1:0] ckpt_tag_t;

    // Pregs 0..NUM_AREGS-1 hold the architectural mapping, so the rest start free.
    localparam fl_ptr_t RESET_TAIL = fl_ptr_t'(NUM_PREGS - NUM_AREGS);
    localparam fl_ptr_t FULL_COUNT = fl_ptr_t'(NUM_PREGS);

    function automatic preg_t resetEntry(input int idx);
        return (idx < NUM_PREGS - NUM_AREGS) ? preg_t'(idx + NUM_AREGS) : preg_t'(0);
    endfunction

endpackage

// File: rtl/phys_free_list_ckpt_table.sv
// Per-branch snapshot of the free-list head pointer: one write port for the
// branch being renamed, one read port for mispredict recovery.
module fl_ckpt_table
    import phys_free_list_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      wr_en,
    input  ckpt_tag_t wr_tag,
    input  fl_ptr_t   wr_ptr,
    input  ckpt_tag_t rd_tag,
    output fl_ptr_t   rd_ptr
);

    fl_ptr_t ckpt_q [NUM_CKPT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                ckpt_q[i] <= '0;
            end
        end else if (wr_en) begin
            ckpt_q[wr_tag] <= wr_ptr;
        end
    end

    assign rd_ptr = ckpt_q[rd_tag];

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical registers feeding rename, refilled by
// retirement and rewound in one cycle from a branch checkpoint on mispredict.
module phys_free_list
    import phys_free_list_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       alloc_req,
    output logic       alloc_valid,
    output logic [6:0] alloc_preg,
    input  logic       free_en,
    input  logic [6:0] free_preg,
    input  logic       ckpt_en,
    input  logic [1:0] ckpt_tag,
    input  logic       mispredict,
    input  logic [1:0] mispredict_tag,
    output logic [7:0] free_count,
    output logic       overflow_err
);

    preg_t   mem_q [NUM_PREGS];
    fl_ptr_t head_q, head_d;
    fl_ptr_t tail_q, tail_d;
    logic    overflow_q, overflow_d;

    fl_ptr_t count;
    fl_ptr_t headAdvanced;
    fl_ptr_t ckptPtr;
    logic    allocFire;
    logic    freeValid;
    logic    listFull;
    logic    freeWrite;

    assign count        = tail_q - head_q;
    assign listFull     = (count == FULL_COUNT);
    // A recovering head is about to jump, so nothing may be granted this cycle.
    assign alloc_valid  = (count != '0) && !mispredict;
    assign allocFire    = alloc_req && alloc_valid;
    assign headAdvanced = head_q + fl_ptr_t'(allocFire);
    assign freeValid    = free_en && (free_preg != '0);
    assign freeWrite    = freeValid && !listFull;

    fl_ckpt_table u_ckpt (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (ckpt_en && !mispredict),
        .wr_tag (ckpt_tag),
        .wr_ptr (headAdvanced),
        .rd_tag (mispredict_tag),
        .rd_ptr (ckptPtr)
    );

    always_comb begin
        head_d     = mispredict ? ckptPtr : headAdvanced;
        tail_d     = tail_q + fl_ptr_t'(freeWrite);
        overflow_d = overflow_q || (freeValid && listFull);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= RESET_TAIL;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                mem_q[i] <= resetEntry(i);
            end
        end else if (freeWrite) begin
            mem_q[tail_q[PREG_W-1:0]] <= free_preg;
        end
    end

    assign alloc_preg   = mem_q[head_q[PREG_W-1:0]];
    assign free_count   = count;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list: drain, refill, checkpoint recovery,
// overflow and asynchronous reset, with hand-computed expectations.
module tb_phys_free_list;

    logic       clk;
    logic       reset;
    logic       alloc_req;
    logic       alloc_valid;
    logic [6:0] alloc_preg;
    logic       free_en;
    logic [6:0] free_preg;
    logic       ckpt_en;
    logic [1:0] ckpt_tag;
    logic       mispredict;
    logic [1:0] mispredict_tag;
    logic [7:0] free_count;
    logic       overflow_err;

    int checks = 0;
    int errors = 0;

    phys_free_list dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .alloc_valid    (alloc_valid),
        .alloc_preg     (alloc_preg),
        .free_en        (free_en),
        .free_preg      (free_preg),
        .ckpt_en        (ckpt_en),
        .ckpt_tag       (ckpt_tag),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .free_count     (free_count),
        .overflow_err   (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic aReq, input logic fEn, input logic [6:0] fPreg,
                                 input logic cEn, input logic [1:0] cTag,
                                 input logic mis, input logic [1:0] mTag);
        alloc_req      = aReq;
        free_en        = fEn;
        free_preg      = fPreg;
        ckpt_en        = cEn;
        ckpt_tag       = cTag;
        mispredict     = mis;
        mispredict_tag = mTag;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic checkState(input string tag, input logic v, input logic [6:0] p, input logic [7:0] c);
        checkOutput({tag, "_valid"}, 32'(alloc_valid), 32'(v));
        checkOutput({tag, "_preg"},  32'(alloc_preg),  32'(p));
        checkOutput({tag, "_count"}, 32'(free_count),  32'(c));
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #12;
        reset = 1'b1;
        tick();

        checkState("reset", 1'b1, 7'd32, 8'd96);
        checkOutput("reset_overflow", 32'(overflow_err), 32'd0);

        // Drain the whole list in order.
        for (int i = 0; i < 96; i++) begin
            applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
            checkOutput($sformatf("drain_grant%0d", i), 32'(alloc_preg), 32'(32 + i));
            checkOutput($sformatf("drain_valid%0d", i), 32'(alloc_valid), 32'd1);
            tick();
        end
        checkState("empty", 1'b0, 7'd0, 8'd0);
        tick();
        checkState("empty_hold", 1'b0, 7'd0, 8'd0);

        // Free into an empty list while requesting: no bypass.
        applyStimulus(1'b1, 1'b1, 7'd5, 1'b0, 2'd0, 1'b0, 2'd0);
        checkOutput("nobypass_valid", 32'(alloc_valid), 32'd0);
        tick();
        idle();
        checkState("after_free5", 1'b1, 7'd5, 8'd1);

        // Asynchronous reset mid-operation.
        reset = 1'b0;
        #1;
        checkState("async_reset", 1'b1, 7'd32, 8'd96);
        reset = 1'b1;
        tick();

        // Three allocs, then checkpoint alongside the fourth.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
            checkOutput($sformatf("pre_ckpt%0d", i), 32'(alloc_preg), 32'(32 + i));
            tick();
        end
        applyStimulus(1'b1, 1'b0, 7'd0, 1'b1, 2'd1, 1'b0, 2'd0);
        checkOutput("ckpt_alloc", 32'(alloc_preg), 32'd35);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
            checkOutput($sformatf("wrongpath%0d", i), 32'(alloc_preg), 32'(36 + i));
            tick();
        end

        // Mispredict to tag 1; a ckpt write to tag 2 the same cycle must be ignored.
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 2'd2, 1'b1, 2'd1);
        checkOutput("mis1_valid", 32'(alloc_valid), 32'd0);
        tick();
        idle();
        checkState("mis1_restored", 1'b1, 7'd36, 8'd92);

        // Two more allocs, then mispredict with concurrent alloc and free of 9.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 7'd9, 1'b0, 2'd0, 1'b1, 2'd1);
        checkOutput("mis2_valid", 32'(alloc_valid), 32'd0);
        tick();
        idle();
        checkState("mis2_restored", 1'b1, 7'd36, 8'd93);

        // Tag 2 still holds its reset value of zero.
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 2'd0, 1'b1, 2'd2);
        tick();
        idle();
        checkState("mis_tag2", 1'b1, 7'd32, 8'd97);

        // Freeing preg 0 is ignored.
        applyStimulus(1'b0, 1'b1, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        idle();
        checkOutput("free_x0_count", 32'(free_count), 32'd97);

        // Refill to full (tail wraps to index 0).
        for (int i = 1; i <= 31; i++) begin
            applyStimulus(1'b0, 1'b1, 7'(i), 1'b0, 2'd0, 1'b0, 2'd0);
            tick();
        end
        idle();
        checkState("full", 1'b1, 7'd32, 8'd128);
        checkOutput("full_overflow", 32'(overflow_err), 32'd0);

        applyStimulus(1'b0, 1'b1, 7'd7, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        idle();
        checkOutput("overflow_set", 32'(overflow_err), 32'd1);
        checkState("overflow_dropped", 1'b1, 7'd32, 8'd128);
        tick();
        checkOutput("overflow_sticky", 32'(overflow_err), 32'd1);

        // Alloc from a full list crosses the wrap boundary cleanly.
        applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        idle();
        checkState("full_minus1", 1'b1, 7'd33, 8'd127);

        reset = 1'b0;
        #1;
        checkOutput("reset_clears_overflow", 32'(overflow_err), 32'd0);
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
